// File: rtl/ctrl_decode_pipe.sv
// Decode-and-carry control pipeline: turns each fetched RV32I instruction into a
// 16-bit control word and carries it with its register specifiers through STAGES registers.
module ctrl_decode_pipe #(
  parameter int STAGES       = 3,
  parameter int FLUSH_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           inst_i,
  input  logic                  inst_valid_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic [16*STAGES-1:0]  stage_ctrl_o,
  output logic [STAGES-1:0]     stage_valid_o,
  output logic [5*STAGES-1:0]   stage_rd_o,
  output logic                  load_use_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef struct packed {
    logic        valid;
    logic [15:0] ctrl;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        uses_rs1;
    logic        uses_rs2;
  } stage_t;

  function automatic logic [3:0] aluFromF3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd;
  logic        w_alt;
  logic        w_illegal, w_jump, w_branch, w_mem_wen, w_reg_wen, w_a_pc, w_b_imm;
  logic [1:0]  w_wb;
  logic [2:0]  w_imm;
  logic [3:0]  w_alu;
  logic        w_uses_rs1, w_uses_rs2;
  logic [15:0] w_ctrl;
  stage_t      w_new;
  stage_t      r_stage [STAGES];

  assign w_opcode = inst_i[6:0];
  assign w_funct3 = inst_i[14:12];
  assign w_funct7 = inst_i[31:25];
  assign w_rd     = inst_i[11:7];
  assign w_alt    = inst_i[30];

  always_comb begin
    w_illegal  = 1'b0;
    w_jump     = 1'b0;
    w_branch   = 1'b0;
    w_mem_wen  = 1'b0;
    w_reg_wen  = 1'b0;
    w_a_pc     = 1'b0;
    w_b_imm    = 1'b0;
    w_wb       = WB_ALU;
    w_imm      = IMM_I;
    w_alu      = ALU_ADD;
    w_uses_rs1 = 1'b1;
    w_uses_rs2 = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_reg_wen  = 1'b1;
        w_uses_rs2 = 1'b1;
        w_alu      = aluFromF3(w_funct3, w_alt);
        // Only SUB and SRA may carry the 0x20 func7 variant
        if (!((w_funct7 == 7'h00) ||
              ((w_funct7 == 7'h20) && ((w_funct3 == 3'd0) || (w_funct3 == 3'd5)))))
          w_illegal = 1'b1;
      end
      OP_I: begin
        w_reg_wen = 1'b1;
        w_b_imm   = 1'b1;
        w_alu     = aluFromF3(w_funct3, (w_funct3 == 3'd5) && w_alt);
        if ((w_funct3 == 3'd1) && w_alt) w_illegal = 1'b1;
      end
      OP_LOAD: begin
        w_reg_wen = 1'b1;
        w_b_imm   = 1'b1;
        w_wb      = WB_MEM;
        if ((w_funct3 == 3'd3) || (w_funct3 == 3'd6) || (w_funct3 == 3'd7)) w_illegal = 1'b1;
      end
      OP_STORE: begin
        w_mem_wen  = 1'b1;
        w_b_imm    = 1'b1;
        w_imm      = IMM_S;
        w_uses_rs2 = 1'b1;
        if (w_funct3 > 3'd2) w_illegal = 1'b1;
      end
      OP_BRANCH: begin
        w_branch   = 1'b1;
        w_a_pc     = 1'b1;
        w_b_imm    = 1'b1;
        w_imm      = IMM_B;
        w_uses_rs2 = 1'b1;
        if ((w_funct3 == 3'd2) || (w_funct3 == 3'd3)) w_illegal = 1'b1;
      end
      OP_LUI: begin
        w_reg_wen  = 1'b1;
        w_b_imm    = 1'b1;
        w_imm      = IMM_U;
        w_alu      = ALU_PASSB;
        w_uses_rs1 = 1'b0;
      end
      OP_AUIPC: begin
        w_reg_wen  = 1'b1;
        w_a_pc     = 1'b1;
        w_b_imm    = 1'b1;
        w_imm      = IMM_U;
        w_uses_rs1 = 1'b0;
      end
      OP_JAL: begin
        w_jump     = 1'b1;
        w_reg_wen  = 1'b1;
        w_a_pc     = 1'b1;
        w_b_imm    = 1'b1;
        w_wb       = WB_PC4;
        w_imm      = IMM_J;
        w_uses_rs1 = 1'b0;
      end
      OP_JALR: begin
        w_jump    = 1'b1;
        w_reg_wen = 1'b1;
        w_b_imm   = 1'b1;
        w_wb      = WB_PC4;
        if (w_funct3 != 3'd0) w_illegal = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Illegal words collapse to a bare flag so nothing downstream acts on them
  assign w_ctrl = w_illegal ? 16'h8000 :
                  {1'b0, w_jump, w_branch, w_mem_wen, w_reg_wen & (w_rd != 5'd0),
                   w_a_pc, w_b_imm, w_wb, w_imm, w_alu};

  always_comb begin
    w_new = '0;
    if (inst_valid_i) begin
      w_new.valid    = 1'b1;
      w_new.ctrl     = w_ctrl;
      w_new.rd       = w_rd;
      w_new.rs1      = inst_i[19:15];
      w_new.rs2      = inst_i[24:20];
      w_new.uses_rs1 = w_uses_rs1 & ~w_illegal;
      w_new.uses_rs2 = w_uses_rs2 & ~w_illegal;
    end
  end

  // Flush beats stall beats advance; an empty stage is always all-zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) r_stage[k] <= '0;
    end else if (flush_i) begin
      r_stage[0] <= '0;
      for (int k = 1; k < STAGES; k++) begin
        if (k <= FLUSH_STAGES) r_stage[k] <= '0;
        else                   r_stage[k] <= r_stage[k-1];
      end
    end else if (stall_i) begin
      r_stage[1] <= '0;
      for (int k = 2; k < STAGES; k++) r_stage[k] <= r_stage[k-1];
    end else begin
      r_stage[0] <= w_new;
      for (int k = 1; k < STAGES; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_out
    assign stage_ctrl_o[16*k +: 16] = r_stage[k].ctrl;
    assign stage_valid_o[k]         = r_stage[k].valid;
    assign stage_rd_o[5*k +: 5]     = r_stage[k].rd;
  end

  assign load_use_o = r_stage[0].valid & r_stage[1].valid &
                      (r_stage[1].ctrl[8:7] == WB_MEM) & (r_stage[1].rd != 5'd0) &
                      ((r_stage[0].uses_rs1 & (r_stage[0].rs1 == r_stage[1].rd)) |
                       (r_stage[0].uses_rs2 & (r_stage[0].rs2 == r_stage[1].rd)));

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Scoreboard bench for ctrl_decode_pipe: directed instructions push expected retire
// words; a negedge monitor pops them as they leave the oldest stage.
module tb_ctrl_decode_pipe;

  localparam int STAGES       = 3;
  localparam int FLUSH_STAGES = 2;

  localparam logic [31:0] ADD3   = 32'h002081B3;
  localparam logic [31:0] LW5    = 32'h0000A283;
  localparam logic [31:0] ADD6   = 32'h00228333;
  localparam logic [31:0] SUB4   = 32'h40208233;
  localparam logic [31:0] AUIPC8 = 32'h00001417;
  localparam logic [31:0] SRAI9  = 32'h4030D493;
  localparam logic [31:0] JAL1   = 32'h000000EF;
  localparam logic [31:0] JALR1  = 32'h000100E7;
  localparam logic [31:0] SW0    = 32'h0020A023;
  localparam logic [31:0] BEQ0   = 32'h00208063;
  localparam logic [31:0] ADDIX0 = 32'h00508013;
  localparam logic [31:0] LUI7   = 32'h123453B7;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [31:0]           inst_i;
  logic                  inst_valid_i;
  logic                  stall_i;
  logic                  flush_i;
  logic [16*STAGES-1:0]  stage_ctrl_o;
  logic [STAGES-1:0]     stage_valid_o;
  logic [5*STAGES-1:0]   stage_rd_o;
  logic                  load_use_o;

  typedef struct {
    logic [15:0] ctrl;
    logic [4:0]  rd;
  } exp_t;

  exp_t expQ [$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  ctrl_decode_pipe #(.STAGES(STAGES), .FLUSH_STAGES(FLUSH_STAGES)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_i       (inst_i),
    .inst_valid_i (inst_valid_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .stage_ctrl_o (stage_ctrl_o),
    .stage_valid_o(stage_valid_o),
    .stage_rd_o   (stage_rd_o),
    .load_use_o   (load_use_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkStage(input int k, input logic [15:0] ctrl, input logic [4:0] rd);
    checkOutput($sformatf("stage%0d ctrl", k), 32'(stage_ctrl_o[16*k +: 16]), 32'(ctrl));
    checkOutput($sformatf("stage%0d rd", k), 32'(stage_rd_o[5*k +: 5]), 32'(rd));
  endtask

  task automatic checkAllClear(input string tag);
    checkOutput({tag, " valid"}, 32'(stage_valid_o), 32'd0);
    checkOutput({tag, " ctrl"}, 32'(stage_ctrl_o), 32'd0);
    checkOutput({tag, " rd"}, 32'(stage_rd_o), 32'd0);
    checkOutput({tag, " load_use"}, 32'(load_use_o), 32'd0);
  endtask

  // Drive inputs just after a negedge, let one rising edge pass, return at the next negedge
  task automatic applyStimulus(input logic [31:0] inst, input logic v, input logic st, input logic fl);
    inst_i       = inst;
    inst_valid_i = v;
    stall_i      = st;
    flush_i      = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] inst, input logic [15:0] ctrl, input logic [4:0] rd);
    exp_t e;
    e.ctrl = ctrl;
    e.rd   = rd;
    expQ.push_back(e);
    applyStimulus(inst, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every instruction leaving the oldest stage must match the head of the queue
  always @(negedge clk) begin
    if (!rst && stage_valid_o[STAGES-1]) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected retire: got ctrl 0x%0h rd %0d, expected nothing",
                 stage_ctrl_o[16*(STAGES-1) +: 16], stage_rd_o[5*(STAGES-1) +: 5]);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("retire ctrl", 32'(stage_ctrl_o[16*(STAGES-1) +: 16]), 32'(e.ctrl));
        checkOutput("retire rd", 32'(stage_rd_o[5*(STAGES-1) +: 5]), 32'(e.rd));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    inst_i       = 32'h0;
    inst_valid_i = 1'b0;
    stall_i      = 1'b0;
    flush_i      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkAllClear("reset");
    rst = 1'b0;

    // Work in flight is lost on an asynchronous mid-stream reset
    applyStimulus(ADD3, 1'b1, 1'b0, 1'b0);
    applyStimulus(LW5, 1'b1, 1'b0, 1'b0);
    checkOutput("prereset valid", 32'(stage_valid_o), 32'b011);
    inst_i       = 32'h0;
    inst_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1 checkAllClear("async reset");
    @(negedge clk);
    rst = 1'b0;

    issue(ADD3, 16'h0800, 5'd3);
    checkOutput("flow s0 valid", 32'(stage_valid_o), 32'b001);
    checkStage(0, 16'h0800, 5'd3);
    idle(1);
    checkOutput("flow s1 valid", 32'(stage_valid_o), 32'b010);
    checkStage(1, 16'h0800, 5'd3);
    idle(1);
    checkOutput("flow s2 valid", 32'(stage_valid_o), 32'b100);
    checkStage(2, 16'h0800, 5'd3);
    idle(1);

    // Load-use with the hazard fed back as stall
    issue(LW5, 16'h0A80, 5'd5);
    checkOutput("lw alone load_use", 32'(load_use_o), 32'd0);
    issue(ADD6, 16'h0800, 5'd6);
    checkOutput("load_use raised", 32'(load_use_o), 32'd1);
    applyStimulus(JAL1, 1'b1, load_use_o, 1'b0);
    checkOutput("stall valid", 32'(stage_valid_o), 32'b101);
    checkStage(0, 16'h0800, 5'd6);
    checkOutput("load_use cleared", 32'(load_use_o), 32'd0);
    idle(1);
    checkOutput("after stall valid", 32'(stage_valid_o), 32'b010);
    checkStage(1, 16'h0800, 5'd6);
    idle(2);

    // Two-cycle stall: stage 0 held, two bubbles behind it
    issue(SUB4, 16'h0801, 5'd4);
    issue(AUIPC8, 16'h0E30, 5'd8);
    applyStimulus(ADDIX0, 1'b1, 1'b1, 1'b0);
    checkOutput("stall1 valid", 32'(stage_valid_o), 32'b101);
    applyStimulus(ADDIX0, 1'b1, 1'b1, 1'b0);
    checkOutput("stall2 valid", 32'(stage_valid_o), 32'b001);
    checkStage(0, 16'h0E30, 5'd8);
    idle(3);

    // Flush kills stages 0-1 and bubbles stage 2; stall and inst are ignored
    issue(BEQ0, 16'h2620, 5'd0);
    applyStimulus(JAL1, 1'b1, 1'b0, 1'b0);
    applyStimulus(JALR1, 1'b1, 1'b0, 1'b0);
    checkOutput("preflush valid", 32'(stage_valid_o), 32'b111);
    applyStimulus(LUI7, 1'b1, 1'b1, 1'b1);
    checkAllClear("flush");
    issue(JALR1, 16'h4B00, 5'd1);
    checkOutput("postflush valid", 32'(stage_valid_o), 32'b001);
    checkStage(0, 16'h4B00, 5'd1);
    idle(3);

    // Decode coverage, including rd=0 and illegal encodings
    issue(JAL1, 16'h4F40, 5'd1);
    issue(SW0, 16'h1210, 5'd0);
    issue(SRAI9, 16'h0A07, 5'd9);
    issue(LUI7, 16'h0A3A, 5'd7);
    issue(ADDIX0, 16'h0200, 5'd0);
    issue(32'h0000007F, 16'h8000, 5'd0);
    issue(32'h00002063, 16'h8000, 5'd0);
    issue(32'h40109013, 16'h8000, 5'd0);
    issue(32'h4020C033, 16'h8000, 5'd0);
    idle(3);

    // Illegal words never claim a source register
    issue(LW5, 16'h0A80, 5'd5);
    issue(32'h0002807F, 16'h8000, 5'd0);
    checkOutput("illegal rs1 load_use", 32'(load_use_o), 32'd0);
    issue(LW5, 16'h0A80, 5'd5);
    issue(32'h00502063, 16'h8000, 5'd0);
    checkOutput("illegal rs2 load_use", 32'(load_use_o), 32'd0);
    idle(3);

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
